// File: rtl/parser_pkg.sv
// parser_pkg: shared parser types plus config-controller constants and FSM states.
package parser_pkg;
  localparam int RULE_NUM = 8;
  localparam int CFG_ADDR_WIDTH = 8;
  localparam int CFG_WORDS_PER_RULE = 5;
  typedef enum logic [1:0] {LAYER_0, LAYER_1, LAYER_2, LAYER_3} layer_e;
  typedef struct packed {
    logic        valid;
    logic [5:0]  hdr_len;
    logic [7:0]  next_type;
    logic [63:0] mask;
    logic [63:0] key;
  } type_rule_t;
  localparam int TYPE_RULE_WIDTH = $bits(type_rule_t);
  typedef enum logic [1:0] {IDLE, COMMIT, DONE} cfg_state_e;
endpackage

// File: rtl/parser_rule_cfg_mirror.sv
// rule_mirror: readback copy of every committed rule, read one 32-bit word at a time.
module rule_mirror
  import parser_pkg::*;
#(
  parameter int LAYER_NUM = 4,
  parameter int RULE_NUM  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_we,
  input  logic [$clog2(LAYER_NUM)-1:0] i_wlayer,
  input  logic [$clog2(RULE_NUM)-1:0]  i_widx,
  input  type_rule_t                  i_wrule,
  input  logic [$clog2(LAYER_NUM)-1:0] i_rlayer,
  input  logic [$clog2(RULE_NUM)-1:0]  i_ridx,
  input  logic [2:0]                  i_rword,
  output logic [31:0]                 o_rdata
);
  type_rule_t mem_q [LAYER_NUM*RULE_NUM];
  logic [8*32-1:0] pad;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LAYER_NUM*RULE_NUM; i++) mem_q[i] <= '0;
    end else if (i_we) begin
      mem_q[{i_wlayer, i_widx}] <= i_wrule;
    end
  end
  // Zero padding up to eight words makes word 4's upper bits and words 5..7 read as 0.
  assign pad = {{(8*32-TYPE_RULE_WIDTH){1'b0}}, mem_q[{i_rlayer, i_ridx}]};
  assign o_rdata = pad[{i_rword, 5'd0} +: 32];
endmodule

// File: rtl/parser_rule_cfg.sv
// parser_rule_cfg: assembles management-bus words into type rules, commits them to the
// layer tables over valid/ready and mirrors committed rules for readback.
module parser_rule_cfg
  import parser_pkg::*;
#(
  parameter int LAYER_NUM      = 4,
  parameter int RULE_NUM       = parser_pkg::RULE_NUM,
  parameter int WORDS_PER_RULE = CFG_WORDS_PER_RULE
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cfg_valid,
  input  logic                      i_cfg_wr,
  input  logic [CFG_ADDR_WIDTH-1:0] i_cfg_addr,
  input  logic [31:0]               i_cfg_wdata,
  output logic                      o_cfg_ready,
  output logic                      o_cfg_rvalid,
  output logic [31:0]               o_cfg_rdata,
  output logic                      o_cfg_err,
  output logic                      o_rule_valid,
  output logic [1:0]                o_rule_layer,
  output logic [2:0]                o_rule_idx,
  output type_rule_t                o_rule,
  input  logic [LAYER_NUM-1:0]      i_rule_ready
);
  cfg_state_e state_q, state_d;
  logic [TYPE_RULE_WIDTH-1:0] shadow_q, shadow_d;
  logic [4:0] tgt_q, tgt_d, mask_q, mask_d;
  logic rvalid_q, rvalid_d, err_q, err_d, commit_we;
  logic [31:0] rdata_q, rdata_d, mirror_rdata;
  logic [2:0] word;
  logic [4:0] tgt;
  logic acc, word_ok, word_last, hit_tgt;
  assign word      = i_cfg_addr[2:0];
  assign tgt       = i_cfg_addr[7:3];
  assign acc       = i_cfg_valid & o_cfg_ready;
  assign word_ok   = word < 3'(WORDS_PER_RULE);
  assign word_last = word == 3'(WORDS_PER_RULE - 1);
  assign hit_tgt   = tgt == tgt_q;
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    tgt_d     = tgt_q;
    mask_d    = mask_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    commit_we = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        if (!i_cfg_wr) begin
          rvalid_d = 1'b1;
          rdata_d  = word_ok ? mirror_rdata : '0;
          err_d    = !word_ok;
        end else if (!word_ok) begin
          err_d = 1'b1;
        end else if (word_last) begin
          shadow_d[TYPE_RULE_WIDTH-1:128] = i_cfg_wdata[TYPE_RULE_WIDTH-129:0];
          tgt_d = tgt;
          // Only a full word-0..3 set for this same target may commit.
          if (hit_tgt && &mask_q[3:0]) begin
            mask_d[4] = 1'b1;
            state_d   = COMMIT;
          end else begin
            err_d  = 1'b1;
            mask_d = '0;
          end
        end else begin
          err_d  = !hit_tgt && |mask_q;
          mask_d = (err_d ? 5'd0 : mask_q) | (5'd1 << word);
          shadow_d[{word[1:0], 5'd0} +: 32] = i_cfg_wdata;
          tgt_d  = tgt;
        end
      end
      COMMIT: if (i_rule_ready[tgt_q[4:3]]) begin
        commit_we = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        mask_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      tgt_q    <= '0;
      mask_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      tgt_q    <= tgt_d;
      mask_q   <= mask_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end
  rule_mirror #(.LAYER_NUM(LAYER_NUM), .RULE_NUM(RULE_NUM)) u_mirror (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (commit_we),
    .i_wlayer(tgt_q[4:3]),
    .i_widx  (tgt_q[2:0]),
    .i_wrule (type_rule_t'(shadow_q)),
    .i_rlayer(tgt[4:3]),
    .i_ridx  (tgt[2:0]),
    .i_rword (word),
    .o_rdata (mirror_rdata)
  );
  assign o_cfg_ready  = state_q == IDLE;
  assign o_rule_valid = state_q == COMMIT;
  assign o_cfg_rvalid = rvalid_q;
  assign o_cfg_rdata  = rdata_q;
  assign o_cfg_err    = err_q;
  assign o_rule_layer = tgt_q[4:3];
  assign o_rule_idx   = tgt_q[2:0];
  assign o_rule       = type_rule_t'(shadow_q);
endmodule

// File: tb/tb_parser_rule_cfg.sv
// tb_parser_rule_cfg: directed checks of rule assembly, commit handshake, errors, readback and reset.
module tb_parser_rule_cfg;
  import parser_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, wr = 1'b0;
  logic [7:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] rready = '0;
  logic cfg_ready, rvalid, err, rule_valid;
  logic [31:0] rdata;
  logic [1:0] rule_layer;
  logic [2:0] rule_idx;
  type_rule_t rule;
  int n_chk = 0, n_fail = 0, cyc = 0, vcnt = 0;
  logic [142:0] exp1, exp2;
  int c0, v0;

  parser_rule_cfg dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(valid), .i_cfg_wr(wr),
    .i_cfg_addr(addr), .i_cfg_wdata(wdata), .o_cfg_ready(cfg_ready),
    .o_cfg_rvalid(rvalid), .o_cfg_rdata(rdata), .o_cfg_err(err),
    .o_rule_valid(rule_valid), .o_rule_layer(rule_layer), .o_rule_idx(rule_idx),
    .o_rule(rule), .i_rule_ready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rule_valid) vcnt++;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ad(input logic [1:0] l, input logic [2:0] r, input logic [2:0] w);
    return {l, r, w};
  endfunction

  // Caller sits on a negedge; returns on the negedge after the accepting edge.
  task automatic req(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("req_timeout", {159'd0, cfg_ready}, 160'd1);
    valid = 1'b1; wr = w; addr = a; wdata = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    exp1 = {15'h5555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    exp2 = {15'h7FFF, 32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1};
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {159'd0, cfg_ready}, 160'd1);
    chk("rst_rvalid", {159'd0, rvalid}, 160'd0);
    chk("rst_rdata", {128'd0, rdata}, 160'd0);
    chk("rst_err", {159'd0, err}, 160'd0);
    chk("rst_rule_valid", {159'd0, rule_valid}, 160'd0);
    chk("rst_rule", {12'd0, rule_layer, rule_idx, rule}, 160'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // commit with ready already high
    rready = 4'b0010;
    req(1, ad(1, 3, 0), 32'h11111111);
    req(1, ad(1, 3, 1), 32'h22222222);
    req(1, ad(1, 3, 2), 32'h33333333);
    req(1, ad(1, 3, 3), 32'h44444444);
    chk("t1_no_err", {159'd0, err}, 160'd0);
    req(1, ad(1, 3, 4), 32'h00015555);
    chk("t1_valid", {159'd0, rule_valid}, 160'd1);
    chk("t1_layer_idx", {155'd0, rule_layer, rule_idx}, {155'd0, 2'd1, 3'd3});
    chk("t1_payload", {17'd0, rule}, {17'd0, exp1});
    chk("t1_cfg_ready_busy", {159'd0, cfg_ready}, 160'd0);
    @(negedge clk);
    chk("t1_valid_drop", {159'd0, rule_valid}, 160'd0);
    chk("t1_ready_done", {159'd0, cfg_ready}, 160'd0);
    @(negedge clk);
    chk("t1_ready_back", {159'd0, cfg_ready}, 160'd1);
    chk("t1_valid_cycles", 160'(vcnt), 160'd1);
    req(0, ad(1, 3, 4), 32'h0);
    chk("t1_rd4_rvalid", {159'd0, rvalid}, 160'd1);
    chk("t1_rd4_data", {128'd0, rdata}, 160'h5555);
    req(0, ad(1, 3, 0), 32'h0);
    chk("t1_rd0_data", {128'd0, rdata}, 160'h11111111);
    req(0, ad(1, 3, 2), 32'h0);
    chk("t1_rd2_data", {128'd0, rdata}, 160'h33333333);
    @(negedge clk);
    chk("t1_rvalid_pulse", {159'd0, rvalid}, 160'd0);

    // stalled commit; ready on other layers must not complete it
    rready = 4'b0000;
    req(1, ad(2, 1, 0), 32'hA1A1A1A1);
    req(1, ad(2, 1, 1), 32'hA2A2A2A2);
    req(1, ad(2, 1, 2), 32'hA3A3A3A3);
    req(1, ad(2, 1, 3), 32'hA4A4A4A4);
    req(1, ad(2, 1, 4), 32'hFFFFFFFF);
    rready = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      chk("t2_stall", {16'd0, rule_valid, cfg_ready, rule_layer, rule_idx, rule},
          {16'd0, 1'b1, 1'b0, 2'd2, 3'd1, exp2});
      @(negedge clk);
    end
    rready = 4'b0100;
    @(negedge clk);
    chk("t2_valid_drop", {158'd0, rule_valid, cfg_ready}, 160'd0);
    @(negedge clk);
    chk("t2_ready_back", {159'd0, cfg_ready}, 160'd1);
    req(0, ad(2, 1, 4), 32'h0);
    chk("t2_rd4_data", {128'd0, rdata}, 160'h7FFF);
    req(0, ad(2, 1, 3), 32'h0);
    chk("t2_rd3_data", {128'd0, rdata}, 160'hA4A4A4A4);

    // partial rule discarded by a retarget, then incomplete word 4
    v0 = vcnt;
    req(1, ad(0, 0, 0), 32'hCAFE0000);
    chk("t3_w0_err", {159'd0, err}, 160'd0);
    req(1, ad(0, 0, 1), 32'hCAFE0001);
    chk("t3_w1_err", {159'd0, err}, 160'd0);
    req(1, ad(2, 5, 0), 32'hBEEF0000);
    chk("t3_retarget_err", {159'd0, err}, 160'd1);
    @(negedge clk);
    chk("t3_err_pulse", {159'd0, err}, 160'd0);
    req(1, ad(2, 5, 4), 32'hBEEF0004);
    chk("t3_w4_incomplete_err", {159'd0, err}, 160'd1);
    chk("t3_no_valid", {159'd0, rule_valid}, 160'd0);
    @(negedge clk);
    chk("t3_ready_idle", {158'd0, cfg_ready, rule_valid}, 160'd2);
    chk("t3_no_commit", 160'(vcnt - v0), 160'd0);
    req(0, ad(2, 5, 0), 32'h0);
    chk("t3_mirror_untouched", {128'd0, rdata}, 160'd0);
    req(1, ad(2, 5, 1), 32'hBEEF0001);
    chk("t3_fresh_no_err", {159'd0, err}, 160'd0);

    // out-of-range word index
    req(1, ad(1, 3, 6), 32'hDEADBEEF);
    chk("t4_wr6_err", {159'd0, err}, 160'd1);
    req(0, ad(1, 3, 6), 32'h0);
    chk("t4_rd6", {127'd0, rvalid, err, rdata}, {127'd0, 1'b1, 1'b1, 32'd0});
    req(0, ad(1, 3, 1), 32'h0);
    chk("t4_mirror_kept", {126'd0, rvalid, err, rdata}, {126'd0, 1'b1, 1'b0, 32'h22222222});

    // reset while in COMMIT
    rready = 4'b0000;
    req(1, ad(0, 2, 0), 32'h01010101);
    req(1, ad(0, 2, 1), 32'h02020202);
    req(1, ad(0, 2, 2), 32'h03030303);
    req(1, ad(0, 2, 3), 32'h04040404);
    req(1, ad(0, 2, 4), 32'h00000005);
    chk("t5_in_commit", {159'd0, rule_valid}, 160'd1);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_drop", {159'd0, rule_valid}, 160'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_ready_after", {159'd0, cfg_ready}, 160'd1);
    req(0, ad(0, 2, 0), 32'h0);
    chk("t5_lost_rule", {128'd0, rdata}, 160'd0);
    req(0, ad(1, 3, 0), 32'h0);
    chk("t5_mirror_cleared", {128'd0, rdata}, 160'd0);

    // back-to-back reads of all layer-3 words
    c0 = cyc;
    for (int r = 0; r < 8; r++)
      for (int w = 0; w < 5; w++) begin
        req(0, ad(2'd3, 3'(r), 3'(w)), 32'h0);
        chk("t6_rd", {127'd0, rvalid, rdata}, {127'd0, 1'b1, 32'd0});
      end
    chk("t6_cycles", 160'(cyc - c0), 160'd40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
